// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the FP32 multiplier datapath.
package fp_mul_pkg;

  localparam int unsigned FP32_W     = 32;
  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned FP32_BIAS  = 127;

  typedef enum logic [1:0] {
    EXP_NORMAL,
    EXP_ZERO,
    EXP_OVF,
    EXP_UNF
  } exp_class_t;

endpackage

// File: rtl/exp_classify.sv
// Combinational exponent classifier: signed unbiased-adjusted exponent -> class and
// saturated biased exponent field.
module exp_classify import fp_mul_pkg::*; #(
  parameter int unsigned EXP_W = FP32_EXP_W
) (
  input  logic signed [EXP_W+1:0] e_i,
  input  logic                    zero_i,
  output exp_class_t              class_o,
  output logic        [EXP_W-1:0] exp_o
);

  localparam logic signed [EXP_W+1:0] EMax  = signed'({2'b00, {EXP_W{1'b1}}});
  localparam logic signed [EXP_W+1:0] EZero = '0;

  // Zero operands win over any exponent condition; no subnormals, so E <= 0 flushes.
  always_comb begin
    class_o = EXP_NORMAL;
    exp_o   = e_i[EXP_W-1:0];
    if (zero_i) begin
      class_o = EXP_ZERO;
      exp_o   = '0;
    end else if (e_i >= EMax) begin
      class_o = EXP_OVF;
      exp_o   = '1;
    end else if (e_i <= EZero) begin
      class_o = EXP_UNF;
      exp_o   = '0;
    end
  end

endmodule

// File: rtl/fp_exp_adjust.sv
// Exponent bias removal, normalisation increment and classification for the FP32
// multiplier; two-stage valid/ready pipeline with a saturating exception counter.
module fp_exp_adjust import fp_mul_pkg::*; #(
  parameter int unsigned EXP_W = FP32_EXP_W,
  parameter int unsigned BIAS  = FP32_BIAS,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [EXP_W-1:0] i_exp_sum,
  input  logic             i_exp_carry,
  input  logic             i_mant_msb,
  input  logic             i_sign,
  input  logic             i_zero,
  input  logic             i_ds_ready,
  output logic             o_valid,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_sign,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_exc_cnt
);

  localparam int unsigned EW = EXP_W + 2;

  logic          s1_valid_q, s1_sign_q, s1_zero_q;
  logic [EW-1:0] s1_e_q, e_d;

  logic             s2_valid_q, sign_q, zero_q, ovf_q, unf_q;
  logic [EXP_W-1:0] exp_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s1_load, s2_load, exc_xfer;
  exp_class_t       cls;
  logic [EXP_W-1:0] cls_exp;

  always_comb begin
    s2_load  = !s2_valid_q || i_ds_ready;
    s1_load  = !s1_valid_q || s2_load;
    o_ready  = s1_load;
    exc_xfer = s2_valid_q && i_ds_ready && (ovf_q || unf_q);
    // Two's-complement wrap in EW bits yields the signed result directly.
    e_d = {1'b0, i_exp_carry, i_exp_sum} + EW'(i_mant_msb) - EW'(BIAS);
  end

  exp_classify #(
    .EXP_W(EXP_W)
  ) u_classify (
    .e_i    (signed'(s1_e_q)),
    .zero_i (s1_zero_q),
    .class_o(cls),
    .exp_o  (cls_exp)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_e_q     <= '0;
      s2_valid_q <= 1'b0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_e_q    <= e_d;
          s1_sign_q <= i_sign;
          s1_zero_q <= i_zero;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          exp_q  <= cls_exp;
          sign_q <= s1_sign_q;
          zero_q <= (cls == EXP_ZERO) || (cls == EXP_UNF);
          ovf_q  <= (cls == EXP_OVF);
          unf_q  <= (cls == EXP_UNF);
        end
      end
      if (i_cnt_clr) begin
        cnt_q <= '0;
      end else if (exc_xfer && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    o_valid     = s2_valid_q;
    o_exp       = exp_q;
    o_sign      = sign_q;
    o_zero      = zero_q;
    o_overflow  = ovf_q;
    o_underflow = unf_q;
    o_exc_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_fp_exp_adjust.sv
// Self-checking bench for fp_exp_adjust: directed boundary vectors plus randomized
// traffic against an arithmetic reference model and an in-order scoreboard.
module tb_fp_exp_adjust;

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, o_ready, i_exp_carry, i_mant_msb, i_sign, i_zero;
  logic       i_ds_ready, o_valid, o_sign, o_zero, o_overflow, o_underflow, i_cnt_clr;
  logic [7:0] i_exp_sum, o_exp, o_exc_cnt;

  always #5 i_clk = ~i_clk;

  fp_exp_adjust dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_exp_sum  (i_exp_sum),
    .i_exp_carry(i_exp_carry),
    .i_mant_msb (i_mant_msb),
    .i_sign     (i_sign),
    .i_zero     (i_zero),
    .i_ds_ready (i_ds_ready),
    .o_valid    (o_valid),
    .o_exp      (o_exp),
    .o_sign     (o_sign),
    .o_zero     (o_zero),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow),
    .i_cnt_clr  (i_cnt_clr),
    .o_exc_cnt  (o_exc_cnt)
  );

  // Result packing: {sign, zero, overflow, underflow, exp[7:0]}
  logic [11:0] dut_res;
  assign dut_res = {o_sign, o_zero, o_overflow, o_underflow, o_exp};

  int          checks = 0;
  int          errors = 0;
  int          cnt_m = 0;
  int          delivered = 0;
  bit          accepted;
  logic [11:0] exp_fifo[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [11:0] ref_result(input logic [7:0] sum, input logic carry,
                                             input logic msb, input logic sign,
                                             input logic zero);
    int e;
    e = int'(carry) * 256 + int'(sum) + int'(msb) - 127;
    if (zero) return {sign, 3'b100, 8'h00};
    if (e >= 255) return {sign, 3'b010, 8'hFF};
    if (e <= 0) return {sign, 3'b101, 8'h00};
    return {sign, 3'b000, 8'(e)};
  endfunction

  task automatic set_in(input logic [7:0] sum, input logic carry, input logic msb,
                        input logic sign, input logic zero);
    i_exp_sum   = sum;
    i_exp_carry = carry;
    i_mant_msb  = msb;
    i_sign      = sign;
    i_zero      = zero;
  endtask

  // Called at a falling edge with inputs applied; observes, then advances one cycle.
  task automatic tick();
    logic exc;
    exc = 1'b0;
    #1;
    check("exc_cnt", o_exc_cnt, cnt_m);
    if (o_valid) begin
      if (exp_fifo.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        check("result", dut_res, exp_fifo[0]);
        if (i_ds_ready) begin
          exc = exp_fifo[0][9] | exp_fifo[0][8];
          void'(exp_fifo.pop_front());
          delivered++;
        end
      end
    end
    accepted = i_valid && o_ready;
    if (accepted) exp_fifo.push_back(ref_result(i_exp_sum, i_exp_carry, i_mant_msb, i_sign,
                                                i_zero));
    if (i_cnt_clr) cnt_m = 0;
    else if (exc && cnt_m < 255) cnt_m++;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_valid    = 1'b0;
    i_cnt_clr  = 1'b0;
    i_ds_ready = 1'b1;
    set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_outputs", {o_valid, dut_res}, 13'h0);
    check("rst_cnt", o_exc_cnt, 0);
    i_rst = 1'b0;
    exp_fifo.delete();
    cnt_m = 0;
    #1;
    check("ready_after_rst", o_ready, 1);
    @(negedge i_clk);
  endtask

  task automatic drain();
    i_valid    = 1'b0;
    i_ds_ready = 1'b1;
    i_cnt_clr  = 1'b0;
    for (int k = 0; k < 10 && exp_fifo.size() != 0; k++) tick();
    check("drain_empty", exp_fifo.size(), 0);
  endtask

  // Single isolated transaction on an idle pipeline, checked against a constant.
  task automatic directed(input string tag, input logic [7:0] sum, input logic carry,
                          input logic msb, input logic sign, input logic zero,
                          input logic [11:0] want);
    set_in(sum, carry, msb, sign, zero);
    i_valid    = 1'b1;
    i_ds_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    #1;
    check({tag, "_lat1"}, o_valid, 0);
    tick();
    check({tag, "_lat2"}, o_valid, 1);
    check(tag, dut_res, want);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    do_reset();

    directed("mul_3x2", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h081);
    directed("mul_1p5sq", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 12'h080);
    directed("max_normal", 8'h7D, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0FE);
    directed("ovf_edge", 8'h7D, 1'b1, 1'b1, 1'b0, 1'b0, 12'h2FF);
    directed("unf_edge", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 12'h500);
    directed("min_normal", 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001);
    directed("zero_prio", 8'hFC, 1'b1, 1'b0, 1'b1, 1'b1, 12'hC00);
    directed("sign_pass", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'h881);
    check("cnt_after_directed", o_exc_cnt, 2);

    // Backpressure: five back-to-back inputs, downstream stalls four cycles.
    begin
      logic [7:0]  bs[5];
      logic        bc[5], bm[5];
      logic [11:0] first;
      int          idx, d0;
      for (int i = 0; i < 5; i++) begin
        bs[i] = 8'($urandom);
        bc[i] = 1'($urandom);
        bm[i] = 1'($urandom);
      end
      first = ref_result(bs[0], bc[0], bm[0], 1'b0, 1'b0);
      idx   = 0;
      d0    = delivered;
      for (int cyc = 0; cyc < 20; cyc++) begin
        i_valid = (idx < 5);
        if (idx < 5) set_in(bs[idx], bc[idx], bm[idx], 1'b0, 1'b0);
        i_ds_ready = !(cyc >= 2 && cyc < 6);
        if (cyc >= 2 && cyc < 6) begin
          #1;
          check("bp_ready_low", o_ready, 0);
          check("bp_valid_hold", o_valid, 1);
          check("bp_data_hold", dut_res, first);
        end
        tick();
        if (accepted) idx++;
      end
      check("bp_accepted", idx, 5);
      check("bp_delivered", delivered - d0, 5);
      drain();
    end

    // Counter saturation.
    do_reset();
    set_in(8'h7D, 1'b1, 1'b1, 1'b0, 1'b0);
    i_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    drain();
    check("cnt_saturated", o_exc_cnt, 8'hFF);

    // Async reset with both stages full.
    set_in(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    i_valid    = 1'b1;
    i_ds_ready = 1'b0;
    tick();
    tick();
    check("both_full_valid", o_valid, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 0);
    check("async_rst_cnt", o_exc_cnt, 0);
    exp_fifo.delete();
    cnt_m   = 0;
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    directed("post_rst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h081);

    // Clear wins over a simultaneous exception transfer.
    set_in(8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    i_valid    = 1'b1;
    i_ds_ready = 1'b1;
    tick();
    tick();
    i_valid = 1'b0;
    tick();
    check("cnt_before_clr", o_exc_cnt, 1);
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    check("clr_priority", o_exc_cnt, 0);
    drain();

    // Randomized traffic with random stalls and clears.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      set_in(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0));
      i_ds_ready = ($urandom_range(0, 3) != 0);
      i_cnt_clr  = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
